// File: rtl/mul_add_seq_if.sv
// Start/done handshake and operand/result bus of the shift-add multiply-accumulate unit.
interface mul_add_seq_if #(
  parameter int unsigned WIDTH = 4
);
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  modport master (
    output start, multiplicand, multiplier, addend,
    input  product, busy, done
  );

  modport slave (
    input  start, multiplicand, multiplier, addend,
    output product, busy, done
  );
endinterface

// File: rtl/mul_add_seq.sv
// Sequential shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// One multiplier bit per clock, fixed WIDTH-cycle latency; reconstructs a divider's dividend.
module mul_add_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  mul_add_seq_if.slave bus
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]    product_q;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    acc_next_c;

  // Conditional add of the shifted multiplicand for the current multiplier bit
  always_comb begin
    acc_next_c = acc_q;
    if (mplier_q[0]) begin
      acc_next_c = acc_q + mcand_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            mcand_q  <= PW'(bus.multiplicand);
            mplier_q <= bus.multiplier;
            acc_q    <= PW'(bus.addend);
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q    <= acc_next_c;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          // Last bit: the final add lands directly in product; start is not looked at here
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            product_q <= acc_next_c;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_mul_add_seq.sv
// Scoreboard bench for mul_add_seq: expected results queued at start, checked at done.
module tb_mul_add_seq;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 2 * W;

  logic clock;
  logic reset;

  mul_add_seq_if #(.WIDTH(W)) bus ();

  mul_add_seq #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] held;

  // Drive one start cycle from a negedge; returns one negedge after the sampling edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.addend       = c;
    bus.start        = 1'b1;
    exp_q.push_back(PW'(a) * PW'(b) + PW'(c));
    @(negedge clock);
    bus.start        = 1'b0;
    bus.multiplicand = W'($urandom);
    bus.multiplier   = W'($urandom);
    bus.addend       = W'($urandom);
  endtask

  // n0 = edges already elapsed since the start edge (inclusive of it).
  task automatic wait_done(input string name, input int n0);
    int n;
    logic [PW-1:0] e;
    n = n0;
    while (bus.done !== 1'b1 && n <= 4 * int'(W)) begin
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy_in_run: got %b expected 1 (cycle %0d)", name, bus.busy, n);
      end
      n_checks++;
      if (bus.product !== held) begin
        n_fail++;
        $display("FAIL %s product_hold_in_run: got %0d expected %0d", name, bus.product, held);
      end
      @(negedge clock);
      n++;
    end
    n_checks++;
    if (n - 1 != int'(W)) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, n - 1, W);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (bus.product !== e) begin
      n_fail++;
      $display("FAIL %s product: got %0d expected %0d", name, bus.product, e);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_at_done: got %b expected 0", name, bus.busy);
    end
    held = e;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    bus.addend = '0;
    held = '0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (bus.product !== '0) begin n_fail++; $display("FAIL reset product: got %0d expected 0", bus.product); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", bus.done); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    start_op(4'd3, 4'd7, 4'd2);
    wait_done("basic", 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if (bus.done !== 1'b1 || bus.product !== 8'd23) begin
        n_fail++;
        $display("FAIL basic_hold: got done=%b product=%0d expected 1 23", bus.done, bus.product);
      end
    end
  endtask

  task automatic test_corners();
    start_op(4'd15, 4'd15, 4'd15);
    wait_done("max_operands", 1);
    start_op(4'd0, 4'd9, 4'd5);
    wait_done("zero_multiplicand", 1);
    start_op(4'd9, 4'd0, 4'd7);
    wait_done("zero_multiplier", 1);
  endtask

  task automatic test_ignore_start();
    start_op(4'd2, 4'd5, 4'd1);
    bus.start = 1'b1;
    bus.multiplicand = 4'd9;
    bus.multiplier = 4'd9;
    bus.addend = 4'd9;
    @(negedge clock);
    bus.start = 1'b0;
    wait_done("ignore_start", 2);
  endtask

  task automatic test_reset_mid_run();
    start_op(4'd6, 4'd6, 4'd3);
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.product !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_run_reset: got product=%0d busy=%b done=%b expected 0 0 0",
               bus.product, bus.busy, bus.done);
    end
    void'(exp_q.pop_front());
    held = '0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0) begin
      n_fail++;
      $display("FAIL idle_after_abort: got busy=%b done=%b product=%0d expected 0 0 0",
               bus.busy, bus.done, bus.product);
    end
    start_op(4'd6, 4'd6, 4'd0);
    wait_done("after_abort", 1);
  endtask

  task automatic test_back_to_back();
    start_op(4'd3, 4'd7, 4'd2);
    wait_done("b2b_first", 1);
    start_op(4'd1, 4'd1, 4'd0);
    wait_done("b2b_second", 1);
  endtask

  task automatic test_start_held();
    bus.multiplicand = 4'd3;
    bus.multiplier = 4'd3;
    bus.addend = 4'd1;
    bus.start = 1'b1;
    for (int n = 1; n <= 2 * int'(W + 1); n++) begin
      @(negedge clock);
      n_checks++;
      if (bus.done !== ((n % int'(W + 1)) == 0)) begin
        n_fail++;
        $display("FAIL start_held done: got %b at cycle %0d", bus.done, n);
      end
      if (bus.done === 1'b1) begin
        n_checks++;
        if (bus.product !== 8'd10) begin
          n_fail++;
          $display("FAIL start_held product: got %0d expected 10", bus.product);
        end
      end
    end
    bus.start = 1'b0;
    held = 8'd10;
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 16; c++) begin
          start_op(W'(a), W'(b), W'(c));
          wait_done("sweep", 1);
        end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_basic();
    test_corners();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_start_held();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
